// File: rtl/spi_flash_pkg.sv
// ============================================================================
//  Package     : spi_flash_pkg
//  Description : Shared opcodes, command encodings, FSM state type and helper
//                functions for the SPI serial-flash command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_flash_pkg;

  // Flash opcodes shifted out in the command phase
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;

  // Host-side cmd_op encodings
  localparam logic [1:0] CMD_RDID = 2'd0;
  localparam logic [1:0] CMD_RDSR = 2'd1;
  localparam logic [1:0] CMD_READ = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  // Fixed data-phase lengths; nine bits so a 256-byte READ fits too
  localparam logic [8:0] RDID_BYTES = 9'd3;
  localparam logic [8:0] RDSR_BYTES = 9'd1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_ADDR     = 3'd3,
    ST_DATA     = 3'd4,
    ST_CS_HOLD  = 3'd5
  } state_t;

  // Opcode byte for a (non-reserved) command encoding
  function automatic logic [7:0] opcode_of(input logic [1:0] op);
    case (op)
      CMD_RDID: opcode_of = OP_RDID;
      CMD_RDSR: opcode_of = OP_RDSR;
      default:  opcode_of = OP_READ;
    endcase
  endfunction

  // Number of data-phase bytes; READ length is carried as count-minus-one
  function automatic logic [8:0] data_bytes(input logic [1:0] op, input logic [7:0] len);
    case (op)
      CMD_RDID: data_bytes = RDID_BYTES;
      CMD_RDSR: data_bytes = RDSR_BYTES;
      default:  data_bytes = {1'b0, len} + 9'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_seq.sv
// ============================================================================
//  Module      : spi_flash_seq
//  Description : SPI serial-flash command sequencer. Accepts RDID / RDSR /
//                READ requests, drives a byte-level shift engine through a
//                start/done handshake, owns chip select and streams received
//                data bytes back to the host.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_seq
  import spi_flash_pkg::*;
#(
  parameter int CS_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        SPICS_N,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx
);

  // Last count value of a chip-select guard interval
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  state_t      state, state_n;
  logic [1:0]  op_q, op_n;
  logic [23:0] addr_q, addr_n;
  logic [7:0]  len_q, len_n;
  logic [15:0] gap_cnt, gap_cnt_n;
  logic [8:0]  byte_cnt, byte_cnt_n;
  logic        busy, busy_n;
  logic        cs_n_n;
  logic        xfer_start_n;
  logic [7:0]  xfer_tx_n;
  logic        rx_valid_n;
  logic [7:0]  rx_data_n;
  logic        cmd_done_n;
  logic        cmd_err_n;
  logic [8:0]  data_last;

  // A request is only taken while nothing else is in flight
  assign cmd_ready = (state == ST_IDLE);

  // Index of the final data-phase byte for the latched command
  assign data_last = data_bytes(op_q, len_q) - 9'd1;

  // Next-state and next-output logic; every transfer state issues one byte
  // when idle and retires it on xfer_done, so only one byte is ever pending
  always_comb begin
    state_n      = state;
    op_n         = op_q;
    addr_n       = addr_q;
    len_n        = len_q;
    gap_cnt_n    = gap_cnt;
    byte_cnt_n   = byte_cnt;
    busy_n       = busy;
    cs_n_n       = SPICS_N;
    xfer_start_n = 1'b0;
    xfer_tx_n    = xfer_tx;
    rx_valid_n   = 1'b0;
    rx_data_n    = rx_data;
    cmd_done_n   = 1'b0;
    cmd_err_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_n   = cmd_op;
          addr_n = cmd_addr;
          len_n  = cmd_len;
          if (cmd_op == CMD_RSVD) begin
            cmd_err_n = 1'b1;
          end else begin
            cs_n_n    = 1'b0;
            gap_cnt_n = 16'd0;
            state_n   = ST_CS_SETUP;
          end
        end
      end

      ST_CS_SETUP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_n  = 16'd0;
          byte_cnt_n = 9'd0;
          state_n    = ST_CMD;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end

      ST_CMD: begin
        if (!busy) begin
          xfer_start_n = 1'b1;
          xfer_tx_n    = opcode_of(op_q);
          busy_n       = 1'b1;
        end else if (xfer_done) begin
          busy_n     = 1'b0;
          byte_cnt_n = 9'd0;
          state_n    = (op_q == CMD_READ) ? ST_ADDR : ST_DATA;
        end
      end

      ST_ADDR: begin
        if (!busy) begin
          xfer_start_n = 1'b1;
          busy_n       = 1'b1;
          case (byte_cnt[1:0])
            2'd0:    xfer_tx_n = addr_q[23:16];
            2'd1:    xfer_tx_n = addr_q[15:8];
            default: xfer_tx_n = addr_q[7:0];
          endcase
        end else if (xfer_done) begin
          busy_n = 1'b0;
          if (byte_cnt == 9'd2) begin
            byte_cnt_n = 9'd0;
            state_n    = ST_DATA;
          end else begin
            byte_cnt_n = byte_cnt + 9'd1;
          end
        end
      end

      ST_DATA: begin
        if (!busy) begin
          xfer_start_n = 1'b1;
          xfer_tx_n    = 8'h00;
          busy_n       = 1'b1;
        end else if (xfer_done) begin
          busy_n     = 1'b0;
          rx_data_n  = xfer_rx;
          rx_valid_n = 1'b1;
          if (byte_cnt == data_last) begin
            byte_cnt_n = 9'd0;
            gap_cnt_n  = 16'd0;
            state_n    = ST_CS_HOLD;
          end else begin
            byte_cnt_n = byte_cnt + 9'd1;
          end
        end
      end

      ST_CS_HOLD: begin
        // CS_GAP low cycles, then one cycle with CS high and cmd_done,
        // so cmd_ready only rises after the completion pulse
        if (gap_cnt == GAP_LAST) begin
          cs_n_n     = 1'b1;
          cmd_done_n = 1'b1;
          gap_cnt_n  = gap_cnt + 16'd1;
        end else if (gap_cnt > GAP_LAST) begin
          gap_cnt_n = 16'd0;
          state_n   = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end

      default: begin
        cs_n_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset parks chip select high
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= 2'd0;
      addr_q     <= 24'd0;
      len_q      <= 8'd0;
      gap_cnt    <= 16'd0;
      byte_cnt   <= 9'd0;
      busy       <= 1'b0;
      SPICS_N    <= 1'b1;
      xfer_start <= 1'b0;
      xfer_tx    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      op_q       <= op_n;
      addr_q     <= addr_n;
      len_q      <= len_n;
      gap_cnt    <= gap_cnt_n;
      byte_cnt   <= byte_cnt_n;
      busy       <= busy_n;
      SPICS_N    <= cs_n_n;
      xfer_start <= xfer_start_n;
      xfer_tx    <= xfer_tx_n;
      rx_valid   <= rx_valid_n;
      rx_data    <= rx_data_n;
      cmd_done   <= cmd_done_n;
      cmd_err    <= cmd_err_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_seq.sv
// ============================================================================
//  Module      : tb_spi_flash_seq
//  Description : Self-checking bench for spi_flash_seq with a byte-engine
//                model and a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_seq;
  import spi_flash_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [23:0] cmd_addr = 24'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_done;
  logic        cmd_err;
  logic        SPICS_N;
  logic        xfer_start;
  logic [7:0]  xfer_tx;
  logic        xfer_done = 1'b0;
  logic [7:0]  xfer_rx = 8'h00;

  spi_flash_seq #(.CS_GAP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err),
    .SPICS_N    (SPICS_N),
    .xfer_start (xfer_start),
    .xfer_tx    (xfer_tx),
    .xfer_done  (xfer_done),
    .xfer_rx    (xfer_rx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues and byte-engine response queue
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] eng_rx[$];

  // Event counters maintained by the monitor
  int cyc = 0;
  int start_cnt = 0, rx_cnt = 0, done_cnt = 0, err_cnt = 0;
  int acc_cnt = 0, acc_cyc = 0, done_cyc = 0;
  int cs_low = 0, ready_low = 0, high_run = 0, last_gap = 0;
  int outstanding = 0, timer = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor + byte-engine model: samples DUT outputs on the falling edge
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (reset) begin
      outstanding = 0;
      timer = 0;
      xfer_done = 1'b0;
    end else begin
      xfer_done = 1'b0;
      if (outstanding != 0) begin
        if (timer == 0) begin
          xfer_done = 1'b1;
          if (eng_rx.size() > 0) xfer_rx = eng_rx.pop_front();
          else xfer_rx = 8'h00;
          outstanding = 0;
        end else begin
          timer--;
        end
      end
      if (xfer_start) begin
        start_cnt++;
        if (outstanding != 0) check("overlap", 1, 0);
        check("start_cs_low", SPICS_N, 0);
        if (exp_tx.size() == 0) check("tx_extra", {24'd0, xfer_tx}, 32'hFFFF);
        else begin
          e = exp_tx.pop_front();
          check("xfer_tx", xfer_tx, e);
        end
        outstanding = 1;
        timer = 2;
      end
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) check("rx_extra", {24'd0, rx_data}, 32'hFFFF);
        else begin
          e = exp_rx.pop_front();
          check("rx_data", rx_data, e);
        end
      end
      if (cmd_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_cs_high", SPICS_N, 1);
      end
      if (cmd_err) err_cnt++;
      if (!cmd_ready) ready_low++;
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        acc_cyc = cyc + 1;
      end
    end
    if (!SPICS_N) begin
      if (high_run > 0) last_gap = high_run;
      high_run = 0;
      cs_low++;
    end else begin
      high_run++;
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len);
    int base;
    int n;
    base = acc_cnt;
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = addr;
    cmd_len = len;
    n = 0;
    while (acc_cnt == base && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    cmd_valid = 1'b0;
    if (acc_cnt == base) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (done_cnt == base) check("done_timeout", 0, 1);
  endtask

  task automatic push_rdid();
    exp_tx.push_back(8'h9F);
    for (int i = 0; i < 3; i++) exp_tx.push_back(8'h00);
    eng_rx.push_back(8'hE1);
    eng_rx.push_back(8'h20); eng_rx.push_back(8'hBA); eng_rx.push_back(8'h18);
    exp_rx.push_back(8'h20); exp_rx.push_back(8'hBA); exp_rx.push_back(8'h18);
  endtask

  task automatic push_read(input logic [23:0] addr, input int nbytes, input logic [7:0] seed);
    logic [7:0] d;
    exp_tx.push_back(8'h03);
    exp_tx.push_back(addr[23:16]);
    exp_tx.push_back(addr[15:8]);
    exp_tx.push_back(addr[7:0]);
    for (int i = 0; i < 4; i++) eng_rx.push_back(8'hC0 + 8'(i));
    for (int i = 0; i < nbytes; i++) begin
      d = seed ^ 8'(i * 7);
      exp_tx.push_back(8'h00);
      eng_rx.push_back(d);
      exp_rx.push_back(d);
    end
  endtask

  initial begin
    int b_start, b_rx, b_done, b_err, b_cs, b_rdy, a1, d1;
    int n;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n", SPICS_N, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_start", xfer_start, 0);
    check("rst_tx", xfer_tx, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_done", cmd_done, 0);
    check("rst_err", cmd_err, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // RDID
    b_start = start_cnt; b_rx = rx_cnt; b_done = done_cnt; b_cs = cs_low;
    push_rdid();
    drive_cmd(CMD_RDID, 24'h0, 8'h0);
    wait_done(500);
    @(posedge clk); #2;
    check("rdid_starts", start_cnt - b_start, 4);
    check("rdid_rx_cnt", rx_cnt - b_rx, 3);
    check("rdid_done_cnt", done_cnt - b_done, 1);
    check("rdid_cs_window", cs_low - b_cs, done_cyc - acc_cyc);

    // READ 0x012345, two bytes, with explicit data AA,55
    b_rx = rx_cnt;
    exp_tx.push_back(8'h03); exp_tx.push_back(8'h01); exp_tx.push_back(8'h23); exp_tx.push_back(8'h45);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    eng_rx.push_back(8'h11); eng_rx.push_back(8'h22); eng_rx.push_back(8'h33); eng_rx.push_back(8'h44);
    eng_rx.push_back(8'hAA); eng_rx.push_back(8'h55);
    exp_rx.push_back(8'hAA); exp_rx.push_back(8'h55);
    drive_cmd(CMD_READ, 24'h012345, 8'd1);
    wait_done(500);
    check("read2_rx_cnt", rx_cnt - b_rx, 2);

    // READ 256 bytes
    b_rx = rx_cnt; b_done = done_cnt; b_start = start_cnt;
    push_read(24'hABCDEF, 256, 8'h5A);
    drive_cmd(CMD_READ, 24'hABCDEF, 8'd255);
    wait_done(5000);
    @(posedge clk); #2;
    check("read256_rx_cnt", rx_cnt - b_rx, 256);
    check("read256_starts", start_cnt - b_start, 260);
    check("read256_done_cnt", done_cnt - b_done, 1);

    // Reserved op
    b_start = start_cnt; b_err = err_cnt; b_cs = cs_low; b_rdy = ready_low; b_done = done_cnt;
    drive_cmd(CMD_RSVD, 24'h0, 8'h0);
    repeat (6) @(posedge clk);
    #2;
    check("rsvd_err", err_cnt - b_err, 1);
    check("rsvd_starts", start_cnt - b_start, 0);
    check("rsvd_cs", cs_low - b_cs, 0);
    check("rsvd_ready", ready_low - b_rdy, 0);
    check("rsvd_done", done_cnt - b_done, 0);

    // cmd_valid held through an RDSR: second request waits for cmd_done
    for (int k = 0; k < 2; k++) begin
      exp_tx.push_back(8'h05); exp_tx.push_back(8'h00);
      eng_rx.push_back(8'hE5); eng_rx.push_back(8'h40 + 8'(k));
      exp_rx.push_back(8'h40 + 8'(k));
    end
    b_rx = rx_cnt;
    n = acc_cnt;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = CMD_RDSR;
    wait_done(500);
    a1 = acc_cnt - n;
    d1 = done_cyc;
    check("hold_single_accept", a1, 1);
    n = 0;
    while (acc_cnt - (a1 + acc_cnt - acc_cnt) == 0 && n < 0) n++;
    n = 0;
    while (acc_cnt - b_rx < 0 && n < 0) n++;
    n = 0;
    b_err = acc_cnt;
    while (acc_cnt == b_err && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    cmd_valid = 1'b0;
    check("hold_second_accept", acc_cnt - b_err, 1);
    check("hold_after_done", acc_cyc > d1, 1);
    wait_done(500);
    check("hold_cs_gap", last_gap >= 1, 1);
    check("hold_rx_cnt", rx_cnt - b_rx, 2);

    // Reset during READ data byte 2
    b_rx = rx_cnt; b_done = done_cnt;
    push_read(24'h000100, 4, 8'h3C);
    drive_cmd(CMD_READ, 24'h000100, 8'd3);
    n = 0;
    while (rx_cnt - b_rx < 1 && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid_first_byte", rx_cnt - b_rx, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cs_n", SPICS_N, 1);
    exp_tx.delete(); exp_rx.delete(); eng_rx.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("mid_no_more_rx", rx_cnt - b_rx, 1);
    check("mid_no_done", done_cnt - b_done, 0);

    // Fresh RDID after reset
    b_rx = rx_cnt; b_done = done_cnt; b_cs = cs_low;
    push_rdid();
    drive_cmd(CMD_RDID, 24'h0, 8'h0);
    wait_done(500);
    @(posedge clk); #2;
    check("post_rdid_rx", rx_cnt - b_rx, 3);
    check("post_rdid_done", done_cnt - b_done, 1);
    check("post_rdid_cs_window", cs_low - b_cs, done_cyc - acc_cyc);

    check("tx_queue_empty", exp_tx.size(), 0);
    check("rx_queue_empty", exp_rx.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_flash_seq.md
Name: spi_flash_seq

Overview:
Command sequencer for the SPI serial-flash path. It accepts one flash command at a time (RDID, RDSR or READ) from a host-side request port. It drives a byte-level SPI shift engine through a start/done handshake and owns the chip-select line. Received bytes stream back to the host. It sits between the system controller and the SPI byte engine, in the same clock domain as both.

Parameters:
CS_GAP, 2, clk cycles SPICS_N is held low before the first byte and after the last byte (min 1)
OP_RDID, 8'h9F, flash read-identification opcode
OP_RDSR, 8'h05, flash read-status opcode
OP_READ, 8'h03, flash read-data opcode

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host command request
cmd_ready  out  1  high when IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=RDID, 1=RDSR, 2=READ, 3=reserved
cmd_addr  in  24  READ start address; ignored for other ops
cmd_len  in  8  READ byte count minus 1 (0 gives 1 byte, 255 gives 256 bytes)
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  8  received flash byte
cmd_done  out  1  one-cycle pulse when the command completes (SPICS_N already high)
cmd_err  out  1  one-cycle pulse when a reserved op is accepted
SPICS_N  out  1  flash chip select, active low
xfer_start  out  1  one-cycle pulse to the byte engine
xfer_tx  out  8  byte to shift out; valid in the xfer_start cycle
xfer_done  in  1  one-cycle pulse from the byte engine when a byte completes
xfer_rx  in  8  byte shifted in; valid in the xfer_done cycle

Behaviour:
- Reset values: SPICS_N=1, cmd_ready=1, xfer_start=0, xfer_tx=0, rx_valid=0, rx_data=0, cmd_done=0, cmd_err=0, state=IDLE, all counters 0.
- Reset mid-command: SPICS_N goes high on the first edge with reset high. No further rx_valid or cmd_done pulses are issued. The byte engine shares this reset.
- States: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA -> CS_HOLD -> IDLE.
- IDLE: on accept, latch op/addr/len.
  - op=3: pulse cmd_err next cycle, stay IDLE, SPICS_N stays high.
  - Otherwise drive SPICS_N=0 and go to CS_SETUP.
- CS_SETUP: wait CS_GAP cycles, then go to CMD.
- CMD: pulse xfer_start with the opcode, wait for xfer_done. The rx byte of the opcode phase is discarded. READ goes to ADDR; the other ops go to DATA.
- ADDR: three transfers, addr[23:16], addr[15:8], addr[7:0]; rx bytes discarded. Then go to DATA.
- DATA: transfers with xfer_tx=8'h00.
  - Byte count: RDID=3, RDSR=1, READ=cmd_len+1. The count is 9 bits wide so 256 does not wrap.
  - On each xfer_done: rx_data<=xfer_rx and rx_valid=1 in the following cycle.
  - After the last byte, go to CS_HOLD.
- CS_HOLD: wait CS_GAP cycles with SPICS_N low. Then set SPICS_N=1 and pulse cmd_done in that same cycle. Go to IDLE, with cmd_ready=1 the next cycle.
- Byte handshake: exactly one byte is outstanding at a time. The next xfer_start is issued no earlier than the cycle after xfer_done. xfer_done seen while no transfer is outstanding is ignored.
- No rx backpressure: the host must sink every rx_valid.
- cmd_valid while busy: cmd_ready=0, request not latched, no side effects.
- Back-to-back commands: SPICS_N is high for at least 1 cycle between commands.

Decomposition:
- Package spi_flash_pkg holds:
  - the opcode constants (OP_RDID/OP_RDSR/OP_READ);
  - the cmd_op encodings;
  - the state enum;
  - RDID_BYTES=3 and RDSR_BYTES=1.
- No sub-module inside. The byte engine (spi_byte_xfer) is a sibling, wired with this block in the parent spi_flash_top.

Test Plan:
- RDID, byte-engine model returns 20,BA,18 -> xfer_tx sequence 9F,00,00,00; rx_valid x3 with 20,BA,18; cmd_done once; SPICS_N low exactly from accept+1 to the cmd_done cycle.
- READ addr=012345, len=1, model returns AA,55 in the data phase -> xfer_tx 03,01,23,45,00,00; rx_data AA then 55; no rx_valid during the cmd/addr phases.
- READ len=255 -> exactly 256 rx_valid pulses, then cmd_done; counter does not wrap.
- cmd_op=3 -> cmd_err pulse, SPICS_N never low, no xfer_start, cmd_ready stays 1.
- cmd_valid held high during an RDSR -> second request ignored while busy. Accepted only after cmd_done; SPICS_N high at least 1 cycle between commands.
- Reset asserted during READ DATA byte 2 -> SPICS_N=1 on that edge, no further rx_valid or cmd_done; after release, a fresh RDID completes normally.
